// File: rtl/fpalign_pipe.sv
// fpalign_pipe: two-stage alignment stage for the floating-point adder.
//
// Stage 1 compares the operand magnitudes and swaps them so the larger one
// comes first. It captures the larger significand, the shift amount, the
// larger exponent, the sign of the larger operand and the effective
// operation. Stage 2 right-shifts the smaller significand, with its guard
// bits appended, by the exponent difference. It also collects a sticky bit
// for every bit shifted out.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operand pair valid           in_ready   operands accepted this cycle
//   a, b       operands {sign, exp, frac}
//   out_valid  result valid                 out_ready  downstream accepts result
//   x          larger significand {hidden, frac, 1'b0}
//   y          aligned smaller significand {hidden, frac, 1'b0, guard zeros} >> shamt
//   sticky     OR of the smaller-significand bits shifted past the LSB of y
//   biggerexp  effective exponent of the larger operand
//   abig       1 when |a| > |b| (equal magnitudes give 0)
//   sign_out   sign of the larger-magnitude operand
//   eff_sub    a.sign ^ b.sign
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready does not look at in_valid. out_valid and the result hold
// steady while out_valid & ~out_ready. A stage loads when it is empty or when
// the stage after it is emptying in the same cycle. This gives one pair per
// cycle with no bubble.
module fpalign_pipe #(
    parameter int WEXP     = 8,
    parameter int WSIG     = 23,
    parameter int EXTRASIG = 3,
    localparam int WIDTH   = 1 + WEXP + WSIG,
    localparam int WY      = WSIG + EXTRASIG + 2,
    localparam int SHW     = $clog2(WY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WSIG+1:0]  x,
    output logic [WY-1:0]    y,
    output logic             sticky,
    output logic [WEXP-1:0]  biggerexp,
    output logic             abig,
    output logic             sign_out,
    output logic             eff_sub
);

    // ---------------- stage 1 combinational: compare and swap ----------------
    logic [WEXP-1:0] ea, eb, ea_eff, eb_eff, bexp_c, sexp_c, diff_c;
    logic            za, zb, a_gt;
    logic [WSIG+1:0] siga, sigb, bsig_c, ssig_c;
    logic [SHW-1:0]  shamt_c;

    always_comb begin
        ea     = a[WIDTH-2 -: WEXP];
        eb     = b[WIDTH-2 -: WEXP];
        za     = (ea == '0);
        zb     = (eb == '0);
        // Denormals share the exponent of the smallest normal.
        ea_eff = za ? WEXP'(1) : ea;
        eb_eff = zb ? WEXP'(1) : eb;
        siga   = {~za, a[WSIG-1:0], 1'b0};
        sigb   = {~zb, b[WSIG-1:0], 1'b0};
        // Exponent and fraction are contiguous, so one unsigned compare orders
        // the magnitudes. A tie selects B as the larger operand.
        a_gt   = a[WIDTH-2:0] > b[WIDTH-2:0];
        bexp_c = a_gt ? ea_eff : eb_eff;
        sexp_c = a_gt ? eb_eff : ea_eff;
        bsig_c = a_gt ? siga : sigb;
        ssig_c = a_gt ? sigb : siga;
        diff_c = bexp_c - sexp_c;
        // Any shift of WY or more clears y, so saturate the shift at WY.
        shamt_c = (diff_c >= WEXP'(WY)) ? SHW'(WY) : diff_c[SHW-1:0];
    end

    // ---------------- pipeline control ----------------
    logic v1, v2, ld1, ld2, acc;

    assign ld2       = ~v2 | out_ready;
    assign ld1       = ~v1 | ld2;
    assign in_ready  = reset_n & ld1;
    assign acc       = in_valid & in_ready;
    assign out_valid = v2;

    // ---------------- stage 1 registers ----------------
    logic [WSIG+1:0] s1_x, s1_small;
    logic [SHW-1:0]  s1_shamt;
    logic [WEXP-1:0] s1_exp;
    logic            s1_abig, s1_sign, s1_eff;

    // ---------------- stage 2 combinational: shift and sticky ----------------
    logic [WY-1:0] yprelim, y_c;
    logic          sticky_c;

    always_comb begin
        yprelim  = {s1_small, {EXTRASIG{1'b0}}};
        y_c      = yprelim >> s1_shamt;
        sticky_c = 1'b0;
        for (int i = 0; i < WY; i++) begin
            if (i < int'(s1_shamt)) sticky_c = sticky_c | yprelim[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1_x      <= '0;
            s1_small  <= '0;
            s1_shamt  <= '0;
            s1_exp    <= '0;
            s1_abig   <= 1'b0;
            s1_sign   <= 1'b0;
            s1_eff    <= 1'b0;
            x         <= '0;
            y         <= '0;
            sticky    <= 1'b0;
            biggerexp <= '0;
            abig      <= 1'b0;
            sign_out  <= 1'b0;
            eff_sub   <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= acc;
                if (acc) begin
                    s1_x     <= bsig_c;
                    s1_small <= ssig_c;
                    s1_shamt <= shamt_c;
                    s1_exp   <= bexp_c;
                    s1_abig  <= a_gt;
                    s1_sign  <= a_gt ? a[WIDTH-1] : b[WIDTH-1];
                    s1_eff   <= a[WIDTH-1] ^ b[WIDTH-1];
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    x         <= s1_x;
                    y         <= y_c;
                    sticky    <= sticky_c;
                    biggerexp <= s1_exp;
                    abig      <= s1_abig;
                    sign_out  <= s1_sign;
                    eff_sub   <= s1_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpalign_pipe.sv
// Self-checking bench for fpalign_pipe (default parameters: 8-bit exponent,
// 23-bit fraction, 3 guard bits). Results are packed as
// {x, y, sticky, biggerexp, abig, sign_out, eff_sub}.
module tb_fpalign_pipe;

    localparam int WEXP = 8;
    localparam int WSIG = 23;
    localparam int WY   = 28;
    localparam int EW   = (WSIG + 2) + WY + 1 + WEXP + 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     a, b;
    logic            out_valid;
    logic            out_ready;
    logic [WSIG+1:0] x;
    logic [WY-1:0]   y;
    logic            sticky;
    logic [WEXP-1:0] biggerexp;
    logic            abig, sign_out, eff_sub;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got;
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic rdone;

    assign got = {x, y, sticky, biggerexp, abig, sign_out, eff_sub};

    fpalign_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .sticky(sticky), .biggerexp(biggerexp),
        .abig(abig), .sign_out(sign_out), .eff_sub(eff_sub)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The shift is done inside a 64-bit word with the smaller significand
    // parked in the upper half. The lower 32 bits then hold exactly what fell
    // off the end, and their OR is the sticky bit.
    function automatic logic [EW-1:0] ref_model(input logic [31:0] ra, input logic [31:0] rb);
        logic [7:0]  ea, eb, bexp, sexp;
        logic [24:0] sa, sb, bsig, ssig;
        logic        agt, sgn;
        int          d, sh;
        logic [63:0] full, shifted;
        ea   = ra[30:23];
        eb   = rb[30:23];
        sa   = {ea != 8'd0, ra[22:0], 1'b0};
        sb   = {eb != 8'd0, rb[22:0], 1'b0};
        if (ea == 8'd0) ea = 8'd1;
        if (eb == 8'd0) eb = 8'd1;
        agt  = ra[30:0] > rb[30:0];
        bexp = agt ? ea : eb;
        sexp = agt ? eb : ea;
        bsig = agt ? sa : sb;
        ssig = agt ? sb : sa;
        sgn  = agt ? ra[31] : rb[31];
        d    = int'(bexp) - int'(sexp);
        sh   = (d > WY) ? WY : d;
        full = {4'b0, ssig, 3'b000, 32'b0};
        shifted = full >> sh;
        return {bsig, shifted[59:32], |shifted[31:0], bexp, agt, sgn, ra[31] ^ rb[31]};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        #2;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output got=%h exp=<none>", got);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if (got !== e) $display("FAIL result got=%h exp=%h", got, e);
                else pass_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                        input logic [EW-1:0] e, output int waits);
        waits = 0;
        @(negedge clk);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (in_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_timeout got=in_ready_low exp=accept a=%h b=%h", ta, tb);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL drain got=%0d_pending exp=0", exp_q.size());
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        a         = 32'h3F800000;
        b         = 32'h3F000000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (got !== '0) $display("FAIL reset_outputs got=%h exp=0", got);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        int w;
        out_ready = 1'b1;
        send(32'h3F800000, 32'h3F000000,
             {25'h1000000, 28'h4000000, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0}, w);
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL latency_1 got=%b exp=0", out_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL latency_2 got=%b exp=1", out_valid);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_vectors();
        int w, wsum;
        wsum = 0;
        out_ready = 1'b1;
        send(32'h3F800000, 32'h3F000000,
             {25'h1000000, 28'h4000000, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0}, w); wsum += w;
        send(32'h4B800000, 32'h3F800001,
             {25'h1000000, 28'h0000008, 1'b1, 8'h97, 1'b1, 1'b0, 1'b0}, w); wsum += w;
        send(32'h7F000000, 32'h00800000,
             {25'h1000000, 28'h0000000, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0}, w); wsum += w;
        send(32'h00000001, 32'h00000002,
             {25'h0000004, 28'h0000010, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0}, w); wsum += w;
        send(32'h3F800000, 32'hBF800000,
             {25'h1000000, 28'h8000000, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1}, w); wsum += w;
        // Shift boundaries: diff 27, diff exactly WY, diff WY+1, b larger with opposite signs.
        send(32'h4D000000, 32'h3F8000FF, ref_model(32'h4D000000, 32'h3F8000FF), w); wsum += w;
        send(32'h4D800000, 32'h3F8000FF, ref_model(32'h4D800000, 32'h3F8000FF), w); wsum += w;
        send(32'h4E000000, 32'h3F800001, ref_model(32'h4E000000, 32'h3F800001), w); wsum += w;
        send(32'h80000003, 32'h40400000, ref_model(32'h80000003, 32'h40400000), w); wsum += w;
        idle();
        total_cnt++;
        if (wsum !== 0) $display("FAIL back_to_back_stalls got=%0d exp=0", wsum);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        logic [31:0] pa[4], pb[4];
        logic [EW-1:0] held;
        for (int i = 0; i < 4; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        @(negedge clk);
        out_ready = 1'b0;
        send(pa[0], pb[0], ref_model(pa[0], pb[0]), w);
        send(pa[1], pb[1], ref_model(pa[1], pb[1]), w);
        @(negedge clk);
        a = pa[2];
        b = pb[2];
        in_valid = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", out_valid);
        else pass_cnt++;
        held = got;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (got !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold got=%h/%b/%b exp=%h/1/0", got, out_valid, in_ready, held);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(pa[2], pb[2], ref_model(pa[2], pb[2]), w);
        send(pa[3], pb[3], ref_model(pa[3], pb[3]), w);
        idle();
        drain();
    endtask

    task automatic test_reset_midstream();
        int w;
        logic [31:0] ra, rb;
        @(negedge clk);
        out_ready = 1'b0;
        ra = $urandom;
        rb = $urandom;
        send(ra, rb, ref_model(ra, rb), w);
        send(rb, ra, ref_model(rb, ra), w);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midreset got=%b/%b exp=0/0", out_valid, in_ready);
        else pass_cnt++;
        // The two queued results were discarded by the reset.
        exp_q.delete();
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL midreset_ghost got=%b exp=0", out_valid);
            else pass_cnt++;
        end
        send(32'h40000000, 32'hC0400000, ref_model(32'h40000000, 32'hC0400000), w);
        idle();
        drain();
    endtask

    task automatic test_random();
        rdone = 1'b0;
        fork
            begin
                int w;
                logic [31:0] ra, rb;
                for (int i = 0; i < 60; i++) begin
                    ra = $urandom;
                    if ($urandom_range(0, 1) == 1) begin
                        rb = $urandom;
                    end else begin
                        rb = $urandom;
                        rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
                    end
                    if ($urandom_range(0, 7) == 0) ra[30:23] = 8'h00;
                    send(ra, rb, ref_model(ra, rb), w);
                end
                idle();
                rdone = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!rdone && n < 3000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 2) != 0);
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fpalign_pipe.md
Name: fpalign_pipe

Overview:
Parametrised, pipelined alignment stage for the floating-point adder. Takes two full IEEE-style operands (sign included) with a valid/ready handshake and swaps them so the larger magnitude comes first. It right-shifts the smaller significand by the exponent difference, saturating at full width, and produces a sticky bit for everything shifted out. Sits between operand capture and the significand add/subtract stage.

Parameters:
WEXP, 8, exponent width
WSIG, 23, stored fraction width (hidden bit excluded)
EXTRASIG, 3, guard bits appended below the significand LSB
WIDTH, 1+WEXP+WSIG, derived operand width
WY, WSIG+EXTRASIG+2, derived aligned-smaller width
SHW, clog2(WY+1), derived shift-amount width

Ports:
clk  in  1  clock; all state changes on rising edge
reset_n  in  1  reset, synchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
a  in  WIDTH  operand A {sign, exp, frac}
b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
x  out  WSIG+2  larger significand {hidden, frac, 1'b0}
y  out  WY  aligned smaller significand
sticky  out  1  OR of all bits of smaller shifted past y LSB
biggerexp  out  WEXP  exponent of larger operand (effective)
abig  out  1  1 when |a| > |b|
sign_out  out  1  sign of larger-magnitude operand
eff_sub  out  1  a.sign XOR b.sign

Behaviour:
- Reset: synchronous on clk when reset_n=0; stage valids v1, v2 cleared; all registered outputs cleared (out_valid=0, x=y=0, sticky=0, biggerexp=0, abig=0, sign_out=0, eff_sub=0). in_ready=0 while reset_n=0. Reset mid-stream discards in-flight operands. No partial results emerge.
- Handshake: transfer on in_valid&in_ready, and on out_valid&out_ready. out_valid=v2. Stage 2 loads when ~v2|out_ready. Stage 1 loads when ~v1|stage-2-loads. in_ready = ~v1|~v2|out_ready (combinational, no dependency on in_valid). Accepted data is never dropped or duplicated. Registered outputs hold stable while out_valid&~out_ready.
- Latency: 2 cycles from accept to out_valid when out_ready held high. Throughput: 1 pair/cycle.
- Stage 1 (compare/swap):
  - zero-exp flag per operand: za = (exp==0).
  - Effective exponent = 1 when exp==0, else exp.
  - Significand val = {~z, frac, 1'b0}.
  - abig = a[WIDTH-2:0] > b[WIDTH-2:0], unsigned; equal magnitudes give abig=0 (B treated as larger).
  - biggerexp and x are selected by abig. diff = biggerexp - smallerexp (never negative).
  - shamt = (diff >= WY) ? WY : diff[SHW-1:0].
  - sign_out and eff_sub are also registered in this stage.
- Stage 2 (shift):
  - yprelim = {smaller val, EXTRASIG zeros} (WY bits).
  - y = yprelim >> shamt.
  - sticky = |(bits of yprelim below position shamt). When shamt=WY: y=0 and sticky=|yprelim.
  - shamt=0 gives sticky=0.
- Exp=all-ones (Inf/NaN) gets no special handling; it flows through arithmetically and downstream flags it.
- Simultaneous accept and emit in the same cycle is legal, with no bubble.

Test Plan:
- a=0x3F800000, b=0x3F000000 -> after 2 cycles: abig=1, biggerexp=0x7F, x=0x1000000, y=0x4000000, sticky=0, sign_out=0, eff_sub=0.
- a=0x4B800000, b=0x3F800001 (diff 24) -> abig=1, biggerexp=0x97, y=0x0000008, sticky=1.
- a=0x7F000000, b=0x00800000 (diff 253, saturates to 28) -> y=0, sticky=1, biggerexp=0xFE.
- Denormals a=0x00000001, b=0x00000002 -> abig=0, biggerexp=0x01, x=0x0000004, y=0x0000010, sticky=0.
- Equal magnitude a=0x3F800000, b=0xBF800000 -> abig=0, sign_out=1, eff_sub=1, y=0x8000000, sticky=0.
- Backpressure and reset:
  - Stream 4 pairs with out_ready=0 -> in_ready falls after 2 accepts and outputs hold stable.
  - Release out_ready -> results emerge in order, with no loss or duplication.
  - Assert reset_n=0 for 1 cycle mid-stream -> out_valid=0 next cycle, and in-flight results never appear.
